// File: rtl/spi_adc_rd_pkg.sv
// Shared definitions for the ADC SPI read engine: state encodings, SPI mode
// constants and default frame geometry (common with the write controller).
package spi_adc_rd_pkg;

  localparam int unsigned NBITS_DEF = 16;
  localparam int unsigned DIV_DEF   = 4;
  localparam int unsigned CH_W_DEF  = 2;

  // SPI mode 0: clock idles low, data sampled on the rising edge.
  localparam logic CPOL      = 1'b0;
  localparam logic SCLK_IDLE = CPOL;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/spi_adc_rd_if.sv
// Request/response and SPI pin bundle of the ADC read engine.
//   strr_i/ch_i : start-read request and channel tag
//   miso_i      : ADC serial data
//   cs_o/sclk_o : ADC chip select (active-low) and SPI clock
//   busy_o      : frame in progress
//   data_o/ch_o : last received word and its tag, qualified by valid_o
interface spi_adc_rd_if
  import spi_adc_rd_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned CH_W  = CH_W_DEF
);
  logic             strr_i;
  logic [CH_W-1:0]  ch_i;
  logic             miso_i;
  logic             cs_o;
  logic             sclk_o;
  logic             busy_o;
  logic [NBITS-1:0] data_o;
  logic [CH_W-1:0]  ch_o;
  logic             valid_o;

  // Read engine side.
  modport slave (
    input  strr_i, ch_i, miso_i,
    output cs_o, sclk_o, busy_o, data_o, ch_o, valid_o
  );

  // Requester / ADC side.
  modport master (
    output strr_i, ch_i, miso_i,
    input  cs_o, sclk_o, busy_o, data_o, ch_o, valid_o
  );
endinterface

// File: rtl/spi_adc_rd_fsm.sv
// Frame sequencer of the ADC read engine: state register, tick divider and
// bit counter. Drives registered cs/sclk/busy/valid and the combinational
// load/shift/done strobes used by the datapath in the top.
//   clk_i, rst_ni : clock, async active-low reset
//   strr_i        : start-read request (honoured in IDLE only)
//   cs_o, sclk_o, busy_o, valid_o : registered pin/status outputs
//   load_c  : start accepted (capture tag, clear shift register)
//   shift_c : end of a high phase (sample MISO)
//   done_c  : frame complete (load output word)
module spi_adc_rd_fsm
  import spi_adc_rd_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned DIV   = DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strr_i,
  output logic cs_o,
  output logic sclk_o,
  output logic busy_o,
  output logic valid_o,
  output logic load_c,
  output logic shift_c,
  output logic done_c
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             tick_c;

  assign tick_c  = (div_cnt_q == DIV_W'(DIV - 1));
  assign cs_o    = cs_q;
  assign sclk_o  = sclk_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= SCLK_IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  // Next state, counters, strobes; outputs are decoded from the next state
  // so they change on the edge that enters each state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    done_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (strr_i) begin
          state_d   = S_SETUP;
          load_c    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      S_SETUP: if (tick_c) state_d = S_HIGH;
      S_HIGH: begin
        if (tick_c) begin
          state_d   = S_LOW;
          shift_c   = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (tick_c) state_d = (bit_cnt_q == CNT_W'(NBITS)) ? S_HOLD : S_HIGH;
      end
      S_HOLD: begin
        if (tick_c) begin
          state_d = S_DONE;
          done_c  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Divider restarts on every state change and idles outside timed states.
    if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    cs_d    = !(state_d == S_SETUP || state_d == S_HIGH || state_d == S_LOW);
    sclk_d  = (state_d == S_HIGH) ? ~SCLK_IDLE : SCLK_IDLE;
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

endmodule

// File: rtl/spi_adc_rd.sv
// SPI read engine for the 4-channel ADC (mode 0). Frames one readout of
// NBITS bits, shifts MISO MSB-first into a SIPO register and presents the
// word with its channel tag and a one-cycle valid pulse.
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : request, SPI pins and result (see spi_adc_rd_if)
module spi_adc_rd
  import spi_adc_rd_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned CH_W  = CH_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  spi_adc_rd_if.slave bus
);

  logic             load_c, shift_c, done_c;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [CH_W-1:0]  tag_q, tag_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  spi_adc_rd_fsm #(
    .NBITS (NBITS),
    .DIV   (DIV)
  ) u_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .strr_i  (bus.strr_i),
    .cs_o    (bus.cs_o),
    .sclk_o  (bus.sclk_o),
    .busy_o  (bus.busy_o),
    .valid_o (bus.valid_o),
    .load_c  (load_c),
    .shift_c (shift_c),
    .done_c  (done_c)
  );

  assign bus.data_o = data_q;
  assign bus.ch_o   = ch_q;

  // SIPO, tag and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      tag_q  <= '0;
      data_q <= '0;
      ch_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      ch_q   <= ch_d;
    end
  end

  // MISO enters at the LSB so the first sample ends up as the MSB.
  always_comb begin
    sr_d   = sr_q;
    tag_d  = tag_q;
    data_d = data_q;
    ch_d   = ch_q;
    if (load_c) begin
      sr_d  = '0;
      tag_d = bus.ch_i;
    end
    if (shift_c) sr_d = {sr_q[NBITS-2:0], bus.miso_i};
    if (done_c) begin
      data_d = sr_q;
      ch_d   = tag_q;
    end
  end

endmodule

// File: tb/tb_spi_adc_rd.sv
// Directed bench for spi_adc_rd (NBITS=16, DIV=4, CH_W=2) with a mode-0 ADC
// slave model that presents the MSB on CS fall and shifts on SCLK falls.
module tb_spi_adc_rd;
  localparam int unsigned NBITS = 16;
  localparam int unsigned DIV   = 4;
  localparam int unsigned CH_W  = 2;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  spi_adc_rd_if #(.NBITS(NBITS), .CH_W(CH_W)) bus_if ();

  spi_adc_rd #(.NBITS(NBITS), .DIV(DIV), .CH_W(CH_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Edge/event logs (cycle numbers) written only by the monitor.
  int              rise_q[$];
  int              fall_q[$];
  int              csf_q[$];
  int              csr_q[$];
  int              val_q[$];
  logic [15:0]     vdata_q[$];
  logic [CH_W-1:0] vch_q[$];

  logic [15:0] slave_words[$];
  logic [15:0] cur_word  = 16'h0;
  int          bit_idx   = -1;
  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;

  // Monitor + ADC slave model, evaluated just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus_if.sclk_o && !prev_sclk) rise_q.push_back(cyc);
    if (!bus_if.sclk_o && prev_sclk) begin
      fall_q.push_back(cyc);
      bit_idx--;
    end
    if (!bus_if.cs_o && prev_cs) begin
      csf_q.push_back(cyc);
      if (slave_words.size() > 0) cur_word = slave_words.pop_front();
      else cur_word = 16'h0;
      bit_idx = NBITS - 1;
    end
    if (bus_if.cs_o && !prev_cs) csr_q.push_back(cyc);
    if (bus_if.cs_o) bit_idx = -1;
    if (bus_if.valid_o) begin
      val_q.push_back(cyc);
      vdata_q.push_back(bus_if.data_o);
      vch_q.push_back(bus_if.ch_o);
    end
    bus_if.miso_i = (bit_idx >= 0) ? cur_word[4'(bit_idx)] : 1'b0;
    prev_sclk = bus_if.sclk_o;
    prev_cs   = bus_if.cs_o;
  end

  task automatic start_read(input logic [CH_W-1:0] ch, output int c0);
    @(negedge clk);
    bus_if.ch_i   = ch;
    bus_if.strr_i = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus_if.strr_i = 1'b0;
  endtask

  task automatic wait_valid(input int n_before, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (val_q.size() > n_before) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_ni        = 1'b0;
    bus_if.strr_i = 1'b0;
    bus_if.ch_i   = '0;
    idle_cycles(3);
    n_cmp++; if (bus_if.cs_o !== 1'b1) begin n_fail++; $display("FAIL reset_cs got %b want 1", bus_if.cs_o); end
    n_cmp++; if (bus_if.sclk_o !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", bus_if.sclk_o); end
    n_cmp++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus_if.busy_o); end
    n_cmp++; if (bus_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus_if.valid_o); end
    n_cmp++; if (bus_if.data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", bus_if.data_o); end
    n_cmp++; if (bus_if.ch_o !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", bus_if.ch_o); end
    rst_ni = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_single_read;
    int c0, nv, nr, ncf, ncr;
    bit ok;
    slave_words.push_back(16'hA5C3);
    nv = val_q.size(); nr = rise_q.size(); ncf = csf_q.size(); ncr = csr_q.size();
    start_read(2'd2, c0);
    n_cmp++; if (bus_if.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus_if.busy_o); end
    wait_valid(nv, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout got %b want 1", ok); end
    if (ok) begin
      n_cmp++; if (val_q[nv] - c0 !== 137) begin n_fail++; $display("FAIL single_latency got %0d want 137", val_q[nv] - c0); end
      n_cmp++; if (vdata_q[nv] !== 16'hA5C3) begin n_fail++; $display("FAIL single_data got %h want a5c3", vdata_q[nv]); end
      n_cmp++; if (vch_q[nv] !== 2'd2) begin n_fail++; $display("FAIL single_ch got %0d want 2", vch_q[nv]); end
      n_cmp++; if (rise_q.size() - nr !== 16) begin n_fail++; $display("FAIL single_rises got %0d want 16", rise_q.size() - nr); end
      n_cmp++; if (csf_q.size() - ncf !== 1) begin n_fail++; $display("FAIL single_cs_falls got %0d want 1", csf_q.size() - ncf); end
      n_cmp++; if (csr_q.size() - ncr !== 1) begin n_fail++; $display("FAIL single_cs_rises got %0d want 1", csr_q.size() - ncr); end
    end
    @(negedge clk);
    n_cmp++; if (bus_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %b want 0", bus_if.valid_o); end
    n_cmp++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", bus_if.busy_o); end
    n_cmp++; if (bus_if.data_o !== 16'hA5C3) begin n_fail++; $display("FAIL single_hold got %h want a5c3", bus_if.data_o); end
    idle_cycles(3);
  endtask

  task automatic test_timing;
    int c0, nv, nr, nf, ncf, ncr, bad_hi, bad_lo;
    bit ok;
    slave_words.push_back(16'h3C5A);
    nv = val_q.size(); nr = rise_q.size(); nf = fall_q.size();
    ncf = csf_q.size(); ncr = csr_q.size();
    start_read(2'd1, c0);
    wait_valid(nv, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timing_timeout got %b want 1", ok); end
    if (ok && rise_q.size() - nr == 16 && fall_q.size() - nf == 16 && csr_q.size() > ncr) begin
      bad_hi = 0; bad_lo = 0;
      for (int i = 0; i < 16; i++) if (fall_q[nf+i] - rise_q[nr+i] != 4) bad_hi++;
      for (int i = 0; i < 15; i++) if (rise_q[nr+i+1] - fall_q[nf+i] != 4) bad_lo++;
      n_cmp++; if (bad_hi !== 0) begin n_fail++; $display("FAIL timing_high got %0d bad phases want 0", bad_hi); end
      n_cmp++; if (bad_lo !== 0) begin n_fail++; $display("FAIL timing_low got %0d bad phases want 0", bad_lo); end
      n_cmp++; if (rise_q[nr] - csf_q[ncf] !== 4) begin n_fail++; $display("FAIL timing_cs_setup got %0d want 4", rise_q[nr] - csf_q[ncf]); end
      n_cmp++; if (csr_q[ncr] - fall_q[nf+15] !== 4) begin n_fail++; $display("FAIL timing_last_low got %0d want 4", csr_q[ncr] - fall_q[nf+15]); end
      n_cmp++; if (val_q[nv] - csr_q[ncr] !== 4) begin n_fail++; $display("FAIL timing_cs_hold got %0d want 4", val_q[nv] - csr_q[ncr]); end
      n_cmp++; if (vdata_q[nv] !== 16'h3C5A) begin n_fail++; $display("FAIL timing_data got %h want 3c5a", vdata_q[nv]); end
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL timing_edges got rises=%0d falls=%0d want 16/16", rise_q.size() - nr, fall_q.size() - nf);
    end
    idle_cycles(3);
  endtask

  task automatic test_ignore_busy;
    int c0, nv;
    bit ok;
    slave_words.push_back(16'h1234);
    slave_words.push_back(16'hDEAD);
    nv = val_q.size();
    start_read(2'd0, c0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 200 && cyc < c0 + (p == 0 ? 10 : 80); i++) @(negedge clk);
      bus_if.ch_i   = 2'd3;
      bus_if.strr_i = 1'b1;
      @(negedge clk);
      bus_if.strr_i = 1'b0;
    end
    wait_valid(nv, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ignore_timeout got %b want 1", ok); end
    // Request raised during the DONE cycle must not start a frame either.
    bus_if.strr_i = 1'b1;
    @(negedge clk);
    bus_if.strr_i = 1'b0;
    idle_cycles(200);
    n_cmp++; if (val_q.size() - nv !== 1) begin n_fail++; $display("FAIL ignore_count got %0d want 1", val_q.size() - nv); end
    if (ok) begin
      n_cmp++; if (vdata_q[nv] !== 16'h1234) begin n_fail++; $display("FAIL ignore_data got %h want 1234", vdata_q[nv]); end
      n_cmp++; if (vch_q[nv] !== 2'd0) begin n_fail++; $display("FAIL ignore_ch got %0d want 0", vch_q[nv]); end
    end
    n_cmp++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got %b want 0", bus_if.busy_o); end
    void'(slave_words.pop_front());
  endtask

  task automatic test_back_to_back;
    int c0, nv, ncf;
    bit ok;
    slave_words.push_back(16'h0001);
    slave_words.push_back(16'hFFFF);
    nv = val_q.size(); ncf = csf_q.size();
    @(negedge clk);
    bus_if.ch_i   = 2'd1;
    bus_if.strr_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 400 && csf_q.size() < ncf + 2; i++) @(negedge clk);
    bus_if.strr_i = 1'b0;
    wait_valid(nv + 1, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout got %b want 1", ok); end
    if (ok) begin
      n_cmp++; if (val_q[nv] - c0 !== 137) begin n_fail++; $display("FAIL b2b_latency got %0d want 137", val_q[nv] - c0); end
      n_cmp++; if (vdata_q[nv] !== 16'h0001) begin n_fail++; $display("FAIL b2b_data0 got %h want 0001", vdata_q[nv]); end
      n_cmp++; if (vdata_q[nv+1] !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_data1 got %h want ffff", vdata_q[nv+1]); end
      n_cmp++; if (val_q[nv+1] - val_q[nv] !== 138) begin n_fail++; $display("FAIL b2b_period got %0d want 138", val_q[nv+1] - val_q[nv]); end
      n_cmp++; if (csf_q[ncf+1] - val_q[nv] !== 2) begin n_fail++; $display("FAIL b2b_gap got %0d want 2", csf_q[ncf+1] - val_q[nv]); end
    end
    idle_cycles(200);
    n_cmp++; if (val_q.size() - nv !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", val_q.size() - nv); end
  endtask

  task automatic test_abort;
    int c0, nv, nf;
    bit ok;
    slave_words.push_back(16'h5555);
    nv = val_q.size(); nf = fall_q.size();
    start_read(2'd1, c0);
    for (int i = 0; i < 200 && fall_q.size() < nf + 7; i++) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus_if.cs_o !== 1'b1) begin n_fail++; $display("FAIL abort_cs got %b want 1", bus_if.cs_o); end
    n_cmp++; if (bus_if.sclk_o !== 1'b0) begin n_fail++; $display("FAIL abort_sclk got %b want 0", bus_if.sclk_o); end
    n_cmp++; if (bus_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus_if.busy_o); end
    n_cmp++; if (bus_if.data_o !== 16'h0) begin n_fail++; $display("FAIL abort_data got %h want 0000", bus_if.data_o); end
    idle_cycles(3);
    rst_ni = 1'b1;
    idle_cycles(150);
    n_cmp++; if (val_q.size() - nv !== 0) begin n_fail++; $display("FAIL abort_no_valid got %0d want 0", val_q.size() - nv); end
    slave_words.push_back(16'h8000);
    start_read(2'd3, c0);
    wait_valid(nv, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_timeout got %b want 1", ok); end
    if (ok) begin
      n_cmp++; if (vdata_q[nv] !== 16'h8000) begin n_fail++; $display("FAIL abort_data_after got %h want 8000", vdata_q[nv]); end
      n_cmp++; if (vch_q[nv] !== 2'd3) begin n_fail++; $display("FAIL abort_ch_after got %0d want 3", vch_q[nv]); end
      n_cmp++; if (val_q[nv] - c0 !== 137) begin n_fail++; $display("FAIL abort_latency got %0d want 137", val_q[nv] - c0); end
    end
    idle_cycles(3);
  endtask

  initial begin
    bus_if.strr_i = 1'b0;
    bus_if.ch_i   = '0;
    test_reset();
    test_single_read();
    test_timing();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
